// File: rtl/mpu_mem_responder.sv
// mpu_mem_responder: external-memory side of the MPU load/store protocol.
// Holds MEM_SLOTS row-major matrices. A host command either streams a slot
// into the register file through mpu_load, or captures a matrix that mpu_store
// pushes out of the register file.
module mpu_mem_responder #(
  parameter int FP          = 32,
  parameter int MAX_M       = 4,
  parameter int MAX_N       = 4,
  parameter int MEM_SLOTS   = 4,
  parameter int REG_ADDR_W  = 3,
  parameter int ACK_TIMEOUT = 16,
  localparam int MW = $clog2(MAX_M + 1),
  localparam int NW = $clog2(MAX_N + 1),
  localparam int SW = $clog2(MEM_SLOTS),
  localparam int IW = $clog2(MAX_M * MAX_N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic                  cmd_op,
  input  logic [SW-1:0]         cmd_slot,
  input  logic [REG_ADDR_W-1:0] cmd_reg_addr,
  output logic                  cmd_ready,
  output logic                  done_out,
  output logic                  error_out,
  input  logic                  host_wr_en,
  input  logic [SW-1:0]         host_wr_slot,
  input  logic [IW-1:0]         host_wr_idx,
  input  logic [FP-1:0]         host_wr_data,
  input  logic [MW-1:0]         host_wr_m,
  input  logic [NW-1:0]         host_wr_n,
  input  logic [SW-1:0]         host_rd_slot,
  input  logic [IW-1:0]         host_rd_idx,
  output logic [FP-1:0]         host_rd_data,
  output logic [MW-1:0]         host_rd_m,
  output logic [NW-1:0]         host_rd_n,
  output logic                  load_en_out,
  output logic [REG_ADDR_W-1:0] mem_load_addr_out,
  output logic [FP-1:0]         mem_load_element_out,
  output logic [MW-1:0]         mem_m_load_size_out,
  output logic [NW-1:0]         mem_n_load_size_out,
  input  logic                  mem_load_ack_in,
  input  logic                  mem_load_error_in,
  output logic                  store_en_out,
  output logic [REG_ADDR_W-1:0] mem_store_addr_out,
  input  logic                  mem_store_en_in,
  input  logic [MW-1:0]         mem_m_store_size_in,
  input  logic [NW-1:0]         mem_n_store_size_in,
  input  logic [FP-1:0]         mem_store_element_in
);

  localparam int DEPTH = 1 << IW;
  localparam int CW    = MW + NW;
  localparam int TW    = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_STREAM, LOAD_WAIT, STORE_REQ, STORE_CAPTURE, FINISH
  } state_t;

  // Element storage is never reset; only the slot sizes mark valid content.
  logic [FP-1:0] mem [MEM_SLOTS][DEPTH];
  logic [MW-1:0] slot_m_q [MEM_SLOTS];
  logic [NW-1:0] slot_n_q [MEM_SLOTS];

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [TW-1:0]         wait_q, wait_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [MW-1:0]         m_q, m_d;
  logic [NW-1:0]         n_q, n_d;
  logic                  bad_q, bad_d;
  logic                  ack_seen_q, ack_seen_d;
  logic                  err_seen_q, err_seen_d;
  logic                  load_en_q, load_en_d;
  logic [REG_ADDR_W-1:0] load_addr_q, load_addr_d;
  logic [FP-1:0]         load_elem_q, load_elem_d;
  logic [MW-1:0]         load_m_q, load_m_d;
  logic [NW-1:0]         load_n_q, load_n_d;
  logic                  store_en_q, store_en_d;
  logic [REG_ADDR_W-1:0] store_addr_q, store_addr_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  mem_we;
  logic [SW-1:0]         mem_wslot;
  logic [IW-1:0]         mem_widx;
  logic [FP-1:0]         mem_wdata;
  logic                  size_we;
  logic [SW-1:0]         size_slot;
  logic [MW-1:0]         size_m;
  logic [NW-1:0]         size_n;
  logic [MW-1:0]         cap_m;
  logic [NW-1:0]         cap_n;
  logic                  cap_bad;
  logic [CW-1:0]         cap_total;
  logic [CW-1:0]         load_total;

  assign cnt_inc    = cnt_q + CW'(1);
  assign load_total = CW'(load_m_q) * CW'(load_n_q);

  // Next-state, next-output and memory/size write selection.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wait_d       = wait_q;
    slot_d       = slot_q;
    m_d          = m_q;
    n_d          = n_q;
    bad_d        = bad_q;
    ack_seen_d   = ack_seen_q;
    err_seen_d   = err_seen_q;
    load_en_d    = 1'b0;
    load_addr_d  = load_addr_q;
    load_elem_d  = load_elem_q;
    load_m_d     = load_m_q;
    load_n_d     = load_n_q;
    store_en_d   = 1'b0;
    store_addr_d = store_addr_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    mem_we       = 1'b0;
    mem_wslot    = host_wr_slot;
    mem_widx     = host_wr_idx;
    mem_wdata    = host_wr_data;
    size_we      = 1'b0;
    size_slot    = host_wr_slot;
    size_m       = host_wr_m;
    size_n       = host_wr_n;
    cap_m        = m_q;
    cap_n        = n_q;
    cap_bad      = bad_q;
    cap_total    = CW'(m_q) * CW'(n_q);

    case (state_q)
      IDLE: begin
        if (host_wr_en) begin
          mem_we  = 1'b1;
          size_we = 1'b1;
        end
        if (cmd_valid) begin
          slot_d     = cmd_slot;
          cnt_d      = '0;
          bad_d      = 1'b0;
          ack_seen_d = 1'b0;
          err_seen_d = 1'b0;
          if (!cmd_op) begin
            if (slot_m_q[cmd_slot] == '0 || slot_n_q[cmd_slot] == '0) begin
              state_d = FINISH;
              done_d  = 1'b1;
              error_d = 1'b1;
            end else begin
              state_d     = LOAD_STREAM;
              load_en_d   = 1'b1;
              load_addr_d = cmd_reg_addr;
              load_m_d    = slot_m_q[cmd_slot];
              load_n_d    = slot_n_q[cmd_slot];
              load_elem_d = mem[cmd_slot][0];
            end
          end else begin
            state_d      = STORE_REQ;
            store_en_d   = 1'b1;
            store_addr_d = cmd_reg_addr;
          end
        end
      end

      LOAD_STREAM: begin
        if (mem_load_ack_in)   ack_seen_d = 1'b1;
        if (mem_load_error_in) err_seen_d = 1'b1;
        if (cnt_inc == load_total) begin
          state_d = LOAD_WAIT;
          wait_d  = TW'(1);
        end else begin
          cnt_d       = cnt_inc;
          load_elem_d = mem[slot_q][cnt_inc[IW-1:0]];
        end
      end

      LOAD_WAIT: begin
        if (err_seen_q || mem_load_error_in) begin
          state_d = FINISH;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else if (ack_seen_q || mem_load_ack_in) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else if (wait_q == TW'(ACK_TIMEOUT - 1)) begin
          state_d = FINISH;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end

      STORE_REQ: begin
        state_d = STORE_CAPTURE;
      end

      STORE_CAPTURE: begin
        if (mem_store_en_in) begin
          if (cnt_q == '0) begin
            cap_m   = mem_m_store_size_in;
            cap_n   = mem_n_store_size_in;
            cap_bad = (cap_m == '0) || (cap_n == '0) ||
                      (cap_m > MW'(MAX_M)) || (cap_n > NW'(MAX_N));
            m_d     = cap_m;
            n_d     = cap_n;
            bad_d   = cap_bad;
          end
          cap_total = CW'(cap_m) * CW'(cap_n);
          if (!cap_bad) begin
            mem_we    = 1'b1;
            mem_wslot = slot_q;
            mem_widx  = cnt_q[IW-1:0];
            mem_wdata = mem_store_element_in;
          end
          cnt_d = cnt_inc;
          if (cnt_inc == cap_total || cap_total == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
            error_d = cap_bad;
            if (!cap_bad) begin
              size_we   = 1'b1;
              size_slot = slot_q;
              size_m    = cap_m;
              size_n    = cap_n;
            end
          end
        end
      end

      FINISH: begin
        state_d      = IDLE;
        load_addr_d  = '0;
        load_elem_d  = '0;
        load_m_d     = '0;
        load_n_d     = '0;
        store_addr_d = '0;
      end

      default: state_d = IDLE;
    endcase
  end

  // Control state and registered protocol outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wait_q       <= '0;
      slot_q       <= '0;
      m_q          <= '0;
      n_q          <= '0;
      bad_q        <= 1'b0;
      ack_seen_q   <= 1'b0;
      err_seen_q   <= 1'b0;
      load_en_q    <= 1'b0;
      load_addr_q  <= '0;
      load_elem_q  <= '0;
      load_m_q     <= '0;
      load_n_q     <= '0;
      store_en_q   <= 1'b0;
      store_addr_q <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wait_q       <= wait_d;
      slot_q       <= slot_d;
      m_q          <= m_d;
      n_q          <= n_d;
      bad_q        <= bad_d;
      ack_seen_q   <= ack_seen_d;
      err_seen_q   <= err_seen_d;
      load_en_q    <= load_en_d;
      load_addr_q  <= load_addr_d;
      load_elem_q  <= load_elem_d;
      load_m_q     <= load_m_d;
      load_n_q     <= load_n_d;
      store_en_q   <= store_en_d;
      store_addr_q <= store_addr_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Slot sizes; cleared on reset so a half-captured store never looks valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_SLOTS; i++) begin
        slot_m_q[i] <= '0;
        slot_n_q[i] <= '0;
      end
    end else if (size_we) begin
      slot_m_q[size_slot] <= size_m;
      slot_n_q[size_slot] <= size_n;
    end
  end

  // Element storage write port shared by host preload and store capture.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_wslot][mem_widx] <= mem_wdata;
  end

  assign cmd_ready            = (state_q == IDLE);
  assign done_out             = done_q;
  assign error_out            = error_q;
  assign host_rd_data         = mem[host_rd_slot][host_rd_idx];
  assign host_rd_m            = slot_m_q[host_rd_slot];
  assign host_rd_n            = slot_n_q[host_rd_slot];
  assign load_en_out          = load_en_q;
  assign mem_load_addr_out    = load_addr_q;
  assign mem_load_element_out = load_elem_q;
  assign mem_m_load_size_out  = load_m_q;
  assign mem_n_load_size_out  = load_n_q;
  assign store_en_out         = store_en_q;
  assign mem_store_addr_out   = store_addr_q;

endmodule

// File: tb/tb_mpu_mem_responder.sv
// Scoreboard bench for mpu_mem_responder: stimulus pushes expected events,
// an independent monitor pops and compares them as the DUT produces them.
module tb_mpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_op;
  logic [1:0]  cmd_slot;
  logic [2:0]  cmd_reg_addr;
  logic        cmd_ready, done_out, error_out;
  logic        host_wr_en;
  logic [1:0]  host_wr_slot, host_rd_slot;
  logic [3:0]  host_wr_idx, host_rd_idx;
  logic [31:0] host_wr_data, host_rd_data;
  logic [2:0]  host_wr_m, host_wr_n, host_rd_m, host_rd_n;
  logic        load_en_out;
  logic [2:0]  mem_load_addr_out;
  logic [31:0] mem_load_element_out;
  logic [2:0]  mem_m_load_size_out, mem_n_load_size_out;
  logic        mem_load_ack_in, mem_load_error_in;
  logic        store_en_out;
  logic [2:0]  mem_store_addr_out;
  logic        mem_store_en_in;
  logic [2:0]  mem_m_store_size_in, mem_n_store_size_in;
  logic [31:0] mem_store_element_in;

  localparam logic [1:0] K_LOAD  = 2'd0;
  localparam logic [1:0] K_STORE = 2'd1;
  localparam logic [1:0] K_DONE  = 2'd2;
  localparam logic [1:0] K_NONE  = 2'd3;

  typedef struct packed {
    logic [1:0]        kind;
    logic [2:0]        addr;
    logic [2:0]        m;
    logic [2:0]        n;
    logic              err;
    int                cyc;
    logic [15:0][31:0] elems;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] fvals [6];

  mpu_mem_responder dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_slot(cmd_slot),
    .cmd_reg_addr(cmd_reg_addr), .cmd_ready(cmd_ready),
    .done_out(done_out), .error_out(error_out),
    .host_wr_en(host_wr_en), .host_wr_slot(host_wr_slot), .host_wr_idx(host_wr_idx),
    .host_wr_data(host_wr_data), .host_wr_m(host_wr_m), .host_wr_n(host_wr_n),
    .host_rd_slot(host_rd_slot), .host_rd_idx(host_rd_idx), .host_rd_data(host_rd_data),
    .host_rd_m(host_rd_m), .host_rd_n(host_rd_n),
    .load_en_out(load_en_out), .mem_load_addr_out(mem_load_addr_out),
    .mem_load_element_out(mem_load_element_out),
    .mem_m_load_size_out(mem_m_load_size_out), .mem_n_load_size_out(mem_n_load_size_out),
    .mem_load_ack_in(mem_load_ack_in), .mem_load_error_in(mem_load_error_in),
    .store_en_out(store_en_out), .mem_store_addr_out(mem_store_addr_out),
    .mem_store_en_in(mem_store_en_in), .mem_m_store_size_in(mem_m_store_size_in),
    .mem_n_store_size_in(mem_n_store_size_in), .mem_store_element_in(mem_store_element_in)
  );

  // Free-running clock and cycle counter used to timestamp events.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [1:0] s, input logic [3:0] i, input logic [31:0] d,
                            input logic [2:0] m, input logic [2:0] n);
    host_wr_en = 1'b1; host_wr_slot = s; host_wr_idx = i;
    host_wr_data = d; host_wr_m = m; host_wr_n = n;
    tick();
    host_wr_en = 1'b0;
  endtask

  task automatic apply_stimulus(input logic op, input logic [1:0] s, input logic [2:0] ra);
    cmd_valid = 1'b1; cmd_op = op; cmd_slot = s; cmd_reg_addr = ra;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic store_beat(input logic [31:0] d, input logic [2:0] m, input logic [2:0] n);
    mem_store_en_in = 1'b1; mem_store_element_in = d;
    mem_m_store_size_in = m; mem_n_store_size_in = n;
    tick();
    mem_store_en_in = 1'b0;
  endtask

  task automatic push_load(input int c, input logic [2:0] a, input logic [2:0] m, input logic [2:0] n);
    exp_t e;
    e = '0;
    e.kind = K_LOAD; e.cyc = c; e.addr = a; e.m = m; e.n = n;
    for (int i = 0; i < 6; i++) e.elems[i] = fvals[i];
    exp_q.push_back(e);
  endtask

  task automatic push_event(input logic [1:0] k, input int c, input logic [2:0] a, input logic err);
    exp_t e;
    e = '0;
    e.kind = k; e.cyc = c; e.addr = a; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    check_output(name, exp_q.size(), 0);
    exp_q.delete();
    tick();
  endtask

  function automatic logic [1:0] head_kind();
    return (exp_q.size() == 0) ? K_NONE : exp_q[0].kind;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    exp_t cur;
    int   left;
    int   k;
    left = 0;
    k    = 0;
    cur  = '0;
    forever begin
      @(negedge clk);
      if (left > 0) begin
        check_output("load_elem", mem_load_element_out, cur.elems[k]);
        check_output("load_en_single", {31'd0, load_en_out}, 32'd0);
        check_output("load_addr_hold", {29'd0, mem_load_addr_out}, {29'd0, cur.addr});
        k++;
        left--;
      end else if (load_en_out) begin
        check_output("load_expected", {30'd0, head_kind()}, {30'd0, K_LOAD});
        if (head_kind() == K_LOAD) begin
          cur = exp_q.pop_front();
          check_output("load_start_cycle", cyc, cur.cyc);
          check_output("load_addr", {29'd0, mem_load_addr_out}, {29'd0, cur.addr});
          check_output("load_m", {29'd0, mem_m_load_size_out}, {29'd0, cur.m});
          check_output("load_n", {29'd0, mem_n_load_size_out}, {29'd0, cur.n});
          check_output("load_elem", mem_load_element_out, cur.elems[0]);
          left = int'(cur.m) * int'(cur.n) - 1;
          k = 1;
        end
      end
      if (store_en_out) begin
        check_output("store_expected", {30'd0, head_kind()}, {30'd0, K_STORE});
        if (head_kind() == K_STORE) begin
          cur = exp_q.pop_front();
          check_output("store_cycle", cyc, cur.cyc);
          check_output("store_addr", {29'd0, mem_store_addr_out}, {29'd0, cur.addr});
        end
      end
      if (done_out) begin
        check_output("done_expected", {30'd0, head_kind()}, {30'd0, K_DONE});
        if (head_kind() == K_DONE) begin
          cur = exp_q.pop_front();
          check_output("done_cycle", cyc, cur.cyc);
          check_output("done_error", {31'd0, error_out}, {31'd0, cur.err});
        end
      end
      if (error_out) check_output("error_with_done", {31'd0, done_out}, 32'd1);
    end
  end

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    int c;
    fvals[0] = 32'h3F800000; fvals[1] = 32'h40000000; fvals[2] = 32'h40400000;
    fvals[3] = 32'h40800000; fvals[4] = 32'h40A00000; fvals[5] = 32'h40C00000;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_slot = '0; cmd_reg_addr = '0;
    host_wr_en = 1'b0; host_wr_slot = '0; host_wr_idx = '0; host_wr_data = '0;
    host_wr_m = '0; host_wr_n = '0; host_rd_slot = '0; host_rd_idx = '0;
    mem_load_ack_in = 1'b0; mem_load_error_in = 1'b0;
    mem_store_en_in = 1'b0; mem_m_store_size_in = '0; mem_n_store_size_in = '0;
    mem_store_element_in = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    check_output("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_output("reset_load_en", {31'd0, load_en_out}, 32'd0);
    check_output("reset_store_en", {31'd0, store_en_out}, 32'd0);
    check_output("reset_done", {31'd0, done_out}, 32'd0);
    check_output("reset_load_elem", mem_load_element_out, 32'd0);
    check_output("reset_slot1_m", {29'd0, host_rd_m}, 32'd0);

    // Load 2x3 from slot 1 into reg 5, ack two cycles after the last element.
    for (int i = 0; i < 6; i++) host_write(2'd1, 4'(i), fvals[i], 3'd2, 3'd3);
    host_rd_slot = 2'd1; host_rd_idx = 4'd3; #1;
    check_output("preload_data", host_rd_data, 32'h40800000);
    check_output("preload_m", {29'd0, host_rd_m}, 32'd2);
    check_output("preload_n", {29'd0, host_rd_n}, 32'd3);
    c = cyc;
    push_load(c + 1, 3'd5, 3'd2, 3'd3);
    push_event(K_DONE, c + 9, 3'd0, 1'b0);
    apply_stimulus(1'b0, 2'd1, 3'd5);
    check_output("busy_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    repeat (7) tick();
    mem_load_ack_in = 1'b1;
    tick();
    mem_load_ack_in = 1'b0;
    wait_drain("load_ack_drain", 40);

    // Same load with ack withheld; host write and cmd while busy are ignored.
    c = cyc;
    push_load(c + 1, 3'd5, 3'd2, 3'd3);
    push_event(K_DONE, c + 22, 3'd0, 1'b1);
    apply_stimulus(1'b0, 2'd1, 3'd5);
    host_wr_en = 1'b1; host_wr_slot = 2'd1; host_wr_idx = 4'd0;
    host_wr_data = 32'h12345678; host_wr_m = 3'd4; host_wr_n = 3'd4;
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_slot = 2'd2; cmd_reg_addr = 3'd7;
    tick();
    host_wr_en = 1'b0; cmd_valid = 1'b0;
    wait_drain("load_timeout_drain", 60);
    host_rd_slot = 2'd1; host_rd_idx = 4'd0; #1;
    check_output("busy_write_ignored_data", host_rd_data, 32'h3F800000);
    check_output("busy_write_ignored_m", {29'd0, host_rd_m}, 32'd2);

    // Ack and error both arrive mid-stream: latched, error wins at LOAD_WAIT entry.
    c = cyc;
    push_load(c + 1, 3'd1, 3'd2, 3'd3);
    push_event(K_DONE, c + 8, 3'd0, 1'b1);
    apply_stimulus(1'b0, 2'd1, 3'd1);
    tick(); tick();
    mem_load_ack_in = 1'b1; mem_load_error_in = 1'b1;
    tick();
    mem_load_ack_in = 1'b0; mem_load_error_in = 1'b0;
    wait_drain("load_latched_drain", 40);

    // Store 4x4 into slot 2 from reg 3 with a two-cycle gap after element 8.
    c = cyc;
    push_event(K_STORE, c + 1, 3'd3, 1'b0);
    push_event(K_DONE, c + 20, 3'd0, 1'b0);
    apply_stimulus(1'b1, 2'd2, 3'd3);
    tick();
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        tick(); tick();
      end
      store_beat(32'(i), 3'd4, 3'd4);
    end
    wait_drain("store_drain", 40);
    host_rd_slot = 2'd2; #1;
    check_output("store_m", {29'd0, host_rd_m}, 32'd4);
    check_output("store_n", {29'd0, host_rd_n}, 32'd4);
    for (int i = 0; i < 16; i++) begin
      host_rd_idx = 4'(i); #1;
      check_output("store_data", host_rd_data, 32'(i));
    end

    // Store with m=5 into slot 3: error after 20 beats, nothing written.
    host_write(2'd3, 4'd0, 32'hDEADBEEF, 3'd0, 3'd0);
    c = cyc;
    push_event(K_STORE, c + 1, 3'd6, 1'b0);
    push_event(K_DONE, c + 22, 3'd0, 1'b1);
    apply_stimulus(1'b1, 2'd3, 3'd6);
    tick();
    for (int i = 0; i < 20; i++) store_beat(32'(100 + i), 3'd5, 3'd4);
    wait_drain("bad_store_drain", 40);
    host_rd_slot = 2'd3; host_rd_idx = 4'd0; #1;
    check_output("bad_store_m", {29'd0, host_rd_m}, 32'd0);
    check_output("bad_store_n", {29'd0, host_rd_n}, 32'd0);
    check_output("bad_store_data", host_rd_data, 32'hDEADBEEF);

    // Load from empty slot 0: error one cycle after the command, no load_en.
    c = cyc;
    push_event(K_DONE, c + 1, 3'd0, 1'b1);
    apply_stimulus(1'b0, 2'd0, 3'd1);
    wait_drain("empty_load_drain", 20);

    // Reset after 5 of 8 store beats into slot 0.
    c = cyc;
    push_event(K_STORE, c + 1, 3'd2, 1'b0);
    apply_stimulus(1'b1, 2'd0, 3'd2);
    tick();
    for (int i = 0; i < 5; i++) store_beat(32'(200 + i), 3'd2, 3'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    host_rd_slot = 2'd0; #1;
    check_output("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_output("rst_store_en", {31'd0, store_en_out}, 32'd0);
    check_output("rst_store_addr", {29'd0, mem_store_addr_out}, 32'd0);
    check_output("rst_done", {31'd0, done_out}, 32'd0);
    check_output("rst_error", {31'd0, error_out}, 32'd0);
    check_output("rst_slot0_m", {29'd0, host_rd_m}, 32'd0);
    check_output("rst_slot0_n", {29'd0, host_rd_n}, 32'd0);
    host_rd_slot = 2'd2; #1;
    check_output("rst_slot2_m", {29'd0, host_rd_m}, 32'd0);
    repeat (4) tick();
    check_output("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mpu_mem_responder.md
Name: mpu_mem_responder

Overview:
- External-memory end of the MPU load/store protocol. It acts as the initiator that feeds mpu_load and the sink that absorbs mpu_store.
- Holds MEM_SLOTS matrices (row-major, up to MAX_M x MAX_N elements each).
- On a host command it either streams a slot into a register-file address through the load interface, or captures a matrix stored from the register file into a slot.
- Sits beside the DUT in mpu_top, replacing direct BFM driving of the mem_* signals.

Parameters:
- FP, 32, element width in bits.
- MAX_M, 4, maximum rows.
- MAX_N, 4, maximum columns.
- MEM_SLOTS, 4, matrices held.
- REG_ADDR_W, 3, register-file address width.
- ACK_TIMEOUT, 16, cycles to wait for load ack before flagging an error.
- Derived values: MW=$clog2(MAX_M+1), NW=$clog2(MAX_N+1), SW=$clog2(MEM_SLOTS), IW=$clog2(MAX_M*MAX_N).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- cmd_valid  in  1  host command strobe
- cmd_op  in  1  0=load (slot->reg), 1=store (reg->slot)
- cmd_slot  in  SW  memory slot
- cmd_reg_addr  in  REG_ADDR_W  register-file address
- cmd_ready  out  1  high in IDLE only
- done_out  out  1  one-cycle completion pulse
- error_out  out  1  one-cycle pulse, coincident with done_out on a failed op
- host_wr_en  in  1  preload element write
- host_wr_slot  in  SW  slot to write
- host_wr_idx  in  IW  row-major element index
- host_wr_data  in  FP  element value
- host_wr_m  in  MW  slot row size
- host_wr_n  in  NW  slot column size
- host_rd_slot  in  SW  read slot
- host_rd_idx  in  IW  read index
- host_rd_data  out  FP  combinational readback
- host_rd_m  out  MW  combinational size readback
- host_rd_n  out  NW  combinational size readback
- load_en_out  out  1  drives mpu_load load_en
- mem_load_addr_out  out  REG_ADDR_W  destination register
- mem_load_element_out  out  FP  streamed element
- mem_m_load_size_out  out  MW  rows
- mem_n_load_size_out  out  NW  columns
- mem_load_ack_in  in  1  from mpu_load
- mem_load_error_in  in  1  from mpu_load
- store_en_out  out  1  drives mpu_store store_en
- mem_store_addr_out  out  REG_ADDR_W  source register
- mem_store_en_in  in  1  element-valid from mpu_store
- mem_m_store_size_in  in  MW  rows
- mem_n_store_size_in  in  NW  columns
- mem_store_element_in  in  FP  stored element

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0 except cmd_ready=1.
  - Counters are cleared.
  - All slot sizes are set to 0; slot element contents are not cleared.
- Host write (host_wr_en):
  - Accepted only in IDLE; ignored otherwise.
  - Writes the element and updates the slot size on the same edge.
- FSM states: IDLE, LOAD_STREAM, LOAD_WAIT, STORE_REQ, STORE_CAPTURE, FINISH.
- IDLE, cmd_valid && op=0:
  - If slot size m=0 or n=0, go to FINISH with error.
  - Otherwise go to LOAD_STREAM with idx=0.
- LOAD_STREAM:
  - load_en_out=1 on the first cycle only.
  - addr and sizes are held constant for the whole state.
  - mem_load_element_out = slot[idx], with idx incrementing each cycle.
  - Lasts exactly m*n cycles, then goes to LOAD_WAIT.
- LOAD_WAIT:
  - Outputs hold the last element.
  - mem_load_ack_in: go to FINISH, success.
  - mem_load_error_in, or ACK_TIMEOUT cycles elapsed without ack: go to FINISH with error.
  - Ack and error in the same cycle: error wins.
  - Ack or error that arrives during LOAD_STREAM is latched and honoured on entry to LOAD_WAIT.
- IDLE, cmd_valid && op=1:
  - Go to STORE_REQ.
  - store_en_out=1 for one cycle; mem_store_addr_out=cmd_reg_addr, held until FINISH.
  - Next state is STORE_CAPTURE.
- STORE_CAPTURE:
  - On the first mem_store_en_in cycle, sizes are latched.
  - Out-of-range sizes (m>MAX_M, n>MAX_N, or either 0) set an error flag and suppress all writes.
  - Each mem_store_en_in cycle writes the element at idx, then idx++.
  - When idx reaches m*n, the slot size is committed and the state goes to FINISH.
  - Gaps (mem_store_en_in low) are permitted and do not advance idx.
- FINISH:
  - done_out=1 (and error_out if flagged) for one cycle, then IDLE.
- cmd_valid is ignored when not IDLE.
- rst mid-operation aborts immediately; a partially captured store does not commit the slot size.
- Latency:
  - Load command to first load_en_out: 1 cycle (registered).
  - Load done pulse: 1 cycle after ack is sampled.

Test Plan:
- Load 2x3: preload slot 1 with 1.0..6.0 (IEEE-754), cmd op=0 slot=1 reg=5. Expect load_en_out one cycle with addr=5, m=2, n=3; elements 0x3F800000..0x40C00000 on 6 consecutive cycles; ack 2 cycles later gives done_out=1, error_out=0.
- Load timeout: same as above with ack withheld. Expect done_out=error_out=1 exactly 16 cycles after the last element.
- Store 4x4: cmd op=1 slot=2 reg=3. Expect store_en_out pulse with addr=3. Drive 16 elements 0..15 with a 2-cycle gap after the 8th. Expect slot 2 readback m=4, n=4, idx k = k, and a done pulse.
- Bad store size: mpu_store presents m=5. Expect done_out=error_out=1 after the element count; slot size is unchanged.
- Empty slot load: load a slot with size 0. Expect load_en_out never asserted, and done_out=error_out=1 at cycle 2.
- Reset mid-store after 5 elements: expect cmd_ready=1, all outputs 0, and slot size still 0 after reset.
